// File: rtl/mux_nxw_to_1_pipe_if.sv
// Valid/ready bus for mux_nxw_to_1_pipe: NUM_IN packed lanes in, one selected lane out.
// master drives the beat and out_ready; slave is the selector block.
interface mux_nxw_to_1_pipe_if #(
    parameter int WIDTH  = 64,
    parameter int NUM_IN = 8,
    parameter int SEL_W  = 3
);
    logic                    in_valid;
    logic                    in_ready;
    logic [NUM_IN*WIDTH-1:0] in;
    logic [SEL_W-1:0]        select;
    logic                    out_valid;
    logic                    out_ready;
    logic [WIDTH-1:0]        out;
    logic [SEL_W-1:0]        out_sel;
    logic                    sel_err;

    modport master (
        output in_valid, in, select, out_ready,
        input  in_ready, out_valid, out, out_sel, sel_err
    );

    modport slave (
        input  in_valid, in, select, out_ready,
        output in_ready, out_valid, out, out_sel, sel_err
    );
endinterface

// File: rtl/mux_nxw_to_1_pipe.sv
// Registered NUM_IN x WIDTH -> 1 lane selector with valid/ready and a 2-entry skid buffer.
// Optional MUX_PERF_CNT_EN adds a saturating 32-bit beat_count of drained beats.
module mux_nxw_to_1_pipe #(
    parameter int WIDTH  = 64,
    parameter int NUM_IN = 8,
    parameter int SEL_W  = 3
) (
    input  logic                clk,
    input  logic                rst,
    mux_nxw_to_1_pipe_if.slave  bus
`ifdef MUX_PERF_CNT_EN
    ,
    output logic [31:0]         beat_count
`endif
);

    generate
        if (NUM_IN < 2 || NUM_IN > 64) begin : g_bad_num_in
            $error("mux_nxw_to_1_pipe: NUM_IN must be in 2..64");
        end
        if ((64'd1 << SEL_W) < 64'(NUM_IN)) begin : g_bad_sel_w
            $error("mux_nxw_to_1_pipe: 2**SEL_W must be >= NUM_IN");
        end
    endgenerate

    logic             main_valid;
    logic [WIDTH-1:0] main_data;
    logic [SEL_W-1:0] main_sel;
    logic             main_err;

    logic             skid_valid;
    logic [WIDTH-1:0] skid_data;
    logic [SEL_W-1:0] skid_sel;
    logic             skid_err;

    logic             in_fire;
    logic             out_fire;
    logic [WIDTH-1:0] pick_data;
    logic             pick_err;

    // in_ready comes straight from a flop, so upstream never sees a path from out_ready.
    assign bus.in_ready = ~skid_valid;
    assign in_fire      = bus.in_valid & ~skid_valid;
    assign out_fire     = main_valid & bus.out_ready;

    // NUM_IN <= 2**SEL_W, so NUM_IN always fits in SEL_W+1 bits.
    assign pick_err = ({1'b0, bus.select} >= (SEL_W+1)'(NUM_IN));

    always_comb begin
        // NOTE: default first so every path assigns pick_data and no latch is inferred.
        pick_data = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (bus.select == SEL_W'(k)) begin
                pick_data = bus.in[k*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: state uses <= so every flop samples pre-edge values regardless of block order.
            main_valid <= 1'b0;
            main_data  <= '0;
            main_sel   <= '0;
            main_err   <= 1'b0;
            skid_valid <= 1'b0;
        end else if (out_fire && skid_valid) begin
            // in_ready is low here, so no new beat can collide with the skid drain.
            main_data  <= skid_data;
            main_sel   <= skid_sel;
            main_err   <= skid_err;
            skid_valid <= 1'b0;
        end else if (in_fire && (!main_valid || out_fire)) begin
            main_valid <= 1'b1;
            main_data  <= pick_data;
            main_sel   <= bus.select;
            main_err   <= pick_err;
        end else if (in_fire) begin
            skid_valid <= 1'b1;
        end else if (out_fire) begin
            main_valid <= 1'b0;
        end
    end

    // NOTE: skid payload has no reset; it is only ever read while skid_valid is set.
    always_ff @(posedge clk) begin
        if (in_fire && main_valid && !out_fire) begin
            skid_data <= pick_data;
            skid_sel  <= bus.select;
            skid_err  <= pick_err;
        end
    end

    assign bus.out_valid = main_valid;
    assign bus.out       = main_data;
    assign bus.out_sel   = main_sel;
    assign bus.sel_err   = main_err;

`ifdef MUX_PERF_CNT_EN
    logic [31:0] beat_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt <= '0;
        end else if (out_fire && (beat_cnt != '1)) begin
            beat_cnt <= beat_cnt + 32'd1;
        end
    end

    assign beat_count = beat_cnt;
`endif

`ifndef SYNTHESIS
    // An unknown select on an accepted beat would silently pick an arbitrary lane.
    always @(posedge clk) begin
        if (!rst && in_fire) begin
            assert (!$isunknown(bus.select))
            else $error("mux_nxw_to_1_pipe: select is X/Z on an accepted beat");
        end
    end
`endif

endmodule

// File: tb/tb_mux_nxw_to_1_pipe.sv
// Bench for mux_nxw_to_1_pipe: a queue model checks an 8-lane instance every cycle,
// directed literal checks pin the model and cover out-of-range select on a 5-lane instance.
module tb_mux_nxw_to_1_pipe;

    localparam int W  = 64;
    localparam int NA = 8;
    localparam int NB = 5;
    localparam int SW = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mux_nxw_to_1_pipe_if #(.WIDTH(W), .NUM_IN(NA), .SEL_W(SW)) ia ();
    mux_nxw_to_1_pipe_if #(.WIDTH(W), .NUM_IN(NB), .SEL_W(SW)) ib ();

`ifdef MUX_PERF_CNT_EN
    logic [31:0] beat_a;
    logic [31:0] beat_b;
`endif

    mux_nxw_to_1_pipe #(.WIDTH(W), .NUM_IN(NA), .SEL_W(SW)) da (
        .clk        (clk),
        .rst        (rst),
        .bus        (ia)
`ifdef MUX_PERF_CNT_EN
        ,
        .beat_count (beat_a)
`endif
    );

    mux_nxw_to_1_pipe #(.WIDTH(W), .NUM_IN(NB), .SEL_W(SW)) db (
        .clk        (clk),
        .rst        (rst),
        .bus        (ib)
`ifdef MUX_PERF_CNT_EN
        ,
        .beat_count (beat_b)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model of instance A: the beats accepted but not yet drained, oldest first.
    typedef struct packed {
        logic [63:0]   data;
        logic [SW-1:0] sel;
        logic          err;
    } beat_t;

    logic [63:0] lanes [NA];
    beat_t       q [$];
    beat_t       last_beat;
    beat_t       nb;
    logic [31:0] exp_cnt;
    logic        m_in_fire;
    logic        m_out_fire;

    initial begin
        for (int k = 0; k < NA; k++) lanes[k] = 64'h1111_1111_1111_1111 * k;
    end

    always @(posedge clk) begin
        m_in_fire  = ia.in_valid && ia.in_ready;
        m_out_fire = ia.out_valid && ia.out_ready;
        if (rst) begin
            q.delete();
            last_beat = '0;
            exp_cnt   = '0;
        end else begin
            if (m_out_fire && q.size() > 0) begin
                void'(q.pop_front());
                if (exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 32'd1;
            end
            if (m_in_fire) begin
                nb.sel  = ia.select;
                nb.err  = (int'(ia.select) >= NA);
                nb.data = nb.err ? 64'd0 : lanes[ia.select];
                q.push_back(nb);
            end
        end
        #1;
        if (q.size() > 0) last_beat = q[0];
        check("m_out_valid", 64'(ia.out_valid), 64'(q.size() > 0));
        check("m_in_ready", 64'(ia.in_ready), 64'(q.size() < 2));
        check("m_out", ia.out, last_beat.data);
        check("m_out_sel", 64'(ia.out_sel), 64'(last_beat.sel));
        check("m_sel_err", 64'(ia.sel_err), 64'(last_beat.err));
`ifdef MUX_PERF_CNT_EN
        check("m_beat_count", 64'(beat_a), 64'(exp_cnt));
`endif
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Holds one beat on A until it is accepted, with random out_ready each cycle.
    task automatic send_a_random(input logic [SW-1:0] sel);
        logic rdy;
        int   guard;
        ia.in_valid = 1'b1;
        ia.select   = sel;
        guard       = 0;
        do begin
            rdy          = ia.in_ready;
            ia.out_ready = 1'($urandom_range(0, 1));
            step();
            guard++;
        end while (!rdy && guard < 100);
        if (!rdy) check("send_timeout", 64'd0, 64'd1);
        ia.in_valid = 1'b0;
    endtask

    initial begin
        logic [23:0] iv_pat;
        logic [23:0] or_pat;
        int          guard;

        ia.in_valid = 1'b0; ia.select = '0; ia.out_ready = 1'b0;
        ib.in_valid = 1'b0; ib.select = '0; ib.out_ready = 1'b0;
        for (int k = 0; k < NA; k++) ia.in[k*W +: W] = 64'h1111_1111_1111_1111 * k;
        for (int k = 0; k < NB; k++) ib.in[k*W +: W] = 64'h1111_1111_1111_1111 * k;
        step();
        step();
        rst = 1'b0;

        check("rst_out_valid", 64'(ia.out_valid), 64'd0);
        check("rst_in_ready", 64'(ia.in_ready), 64'd1);
        check("rst_out", ia.out, 64'd0);
        check("rst_sel_err", 64'(ib.sel_err), 64'd0);

        // Back-to-back select 0..7 with no backpressure.
        ia.out_ready = 1'b1;
        for (int s = 0; s < NA; s++) begin
            ia.in_valid = 1'b1;
            ia.select   = SW'(s);
            step();
            check("t1_valid", 64'(ia.out_valid), 64'd1);
            check("t1_ready", 64'(ia.in_ready), 64'd1);
            if (s == 0) check("t1_lane0", ia.out, 64'h0);
            if (s == 3) check("t1_lane3", ia.out, 64'h3333_3333_3333_3333);
        end
        ia.in_valid = 1'b0;
        check("t1_lane7", ia.out, 64'h7777_7777_7777_7777);
        step();
        check("t1_idle_valid", 64'(ia.out_valid), 64'd0);
        check("t1_idle_hold", ia.out, 64'h7777_7777_7777_7777);

        // Backpressure fills main then skid, then drains in order.
        ia.out_ready = 1'b0;
        ia.in_valid  = 1'b1;
        ia.select    = 3'd2;
        step();
        check("t2_main", ia.out, 64'h2222_2222_2222_2222);
        ia.select = 3'd5;
        step();
        check("t2_ready_low", 64'(ia.in_ready), 64'd0);
        check("t2_hold", ia.out, 64'h2222_2222_2222_2222);
        ia.in_valid = 1'b0;
        step();
        check("t2_hold2", ia.out, 64'h2222_2222_2222_2222);
        ia.out_ready = 1'b1;
        step();
        check("t2_skid_out", ia.out, 64'h5555_5555_5555_5555);
        check("t2_sel5", 64'(ia.out_sel), 64'd5);
        check("t2_ready_back", 64'(ia.in_ready), 64'd1);
        step();
        check("t2_drained", 64'(ia.out_valid), 64'd0);

        // Main full, in_fire and out_fire together: main is replaced, skid stays empty.
        ia.in_valid = 1'b1;
        ia.select   = 3'd1;
        step();
        ia.select = 3'd6;
        step();
        check("t4_replace", ia.out, 64'h6666_6666_6666_6666);
        check("t4_ready", 64'(ia.in_ready), 64'd1);
        ia.in_valid = 1'b0;
        step();

        // Reset with both entries full discards them.
        ia.out_ready = 1'b0;
        ia.in_valid  = 1'b1;
        ia.select    = 3'd3;
        step();
        ia.select = 3'd4;
        step();
        check("t5_full", 64'(ia.in_ready), 64'd0);
        ia.in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t5_rst_valid", 64'(ia.out_valid), 64'd0);
        check("t5_rst_ready", 64'(ia.in_ready), 64'd1);
        check("t5_rst_out", ia.out, 64'd0);
        ia.out_ready = 1'b1;
        ia.in_valid  = 1'b1;
        ia.select    = 3'd1;
        step();
        check("t5_fresh", ia.out, 64'h1111_1111_1111_1111);
        check("t5_fresh_valid", 64'(ia.out_valid), 64'd1);
        ia.in_valid = 1'b0;
        step();

        // Mixed valid/ready pattern, checked by the model every cycle.
        iv_pat = 24'b1011_0111_1101_1110_0111_1011;
        or_pat = 24'b0110_1001_1100_0111_0010_1101;
        for (int i = 0; i < 24; i++) begin
            ia.in_valid  = iv_pat[i];
            ia.out_ready = or_pat[i];
            ia.select    = SW'((i * 3) % NA);
            step();
        end
        ia.in_valid  = 1'b0;
        ia.out_ready = 1'b1;
        step();
        step();
        step();
        check("mix_drained", 64'(ia.out_valid), 64'd0);

        // Five lanes: out-of-range selects transfer as zero data with sel_err.
        ib.out_ready = 1'b1;
        ib.in_valid  = 1'b1;
        ib.select    = 3'd6;
        step();
        check("b_oor_valid", 64'(ib.out_valid), 64'd1);
        check("b_oor_out", ib.out, 64'd0);
        check("b_oor_err", 64'(ib.sel_err), 64'd1);
        check("b_oor_sel", 64'(ib.out_sel), 64'd6);
        ib.select = 3'd3;
        step();
        check("b_lane3", ib.out, 64'h3333_3333_3333_3333);
        check("b_lane3_err", 64'(ib.sel_err), 64'd0);
        ib.select = 3'd4;
        step();
        check("b_lane4", ib.out, 64'h4444_4444_4444_4444);
        ib.select = 3'd5;
        step();
        check("b_sel5_out", ib.out, 64'd0);
        check("b_sel5_err", 64'(ib.sel_err), 64'd1);
        ib.in_valid = 1'b0;
        step();
        check("b_idle", 64'(ib.out_valid), 64'd0);
        check("b_idle_hold", 64'(ib.out_sel), 64'd5);

`ifdef MUX_PERF_CNT_EN
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int n = 0; n < 10; n++) send_a_random(SW'(n % NA));
        guard = 0;
        while ((ia.out_valid || ia.in_ready == 1'b0) && guard < 200) begin
            ia.out_ready = 1'($urandom_range(0, 1));
            step();
            guard++;
        end
        check("perf_drain_done", 64'(ia.out_valid), 64'd0);
        check("perf_count10", 64'(beat_a), 64'd10);
        ia.out_ready = 1'b0;
        ia.in_valid  = 1'b1;
        ia.select    = 3'd0;
        step();
        ia.in_valid = 1'b0;
        force da.beat_cnt = 32'hFFFF_FFFF;
        exp_cnt = 32'hFFFF_FFFF;
        #1;
        release da.beat_cnt;
        ia.out_ready = 1'b1;
        step();
        check("perf_saturate", 64'(beat_a), 64'hFFFF_FFFF);
        step();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
